// File: rtl/module_unidad_ejecucion_if.sv
// rtl/module_unidad_ejecucion_if.sv - instruction handshake and register-bank bus of the execution stage
interface module_unidad_ejecucion_if #(
   parameter int N = 32,
   parameter int W = 8
);
   localparam int AW = $clog2(N);

   logic          instr_valid;
   logic          instr_ready;
   logic [2:0]    op;
   logic [AW-1:0] addr_a;
   logic [AW-1:0] addr_b;
   logic [AW-1:0] addr_dst;
   logic [W-1:0]  rs1;
   logic [W-1:0]  rs2;
   logic [AW-1:0] addr_rs1;
   logic [AW-1:0] addr_rs2;
   logic [AW-1:0] addr_rd;
   logic          we;
   logic [W-1:0]  data_in;
   logic [W-1:0]  result;
   logic          done;

   modport slave (
      input  instr_valid, op, addr_a, addr_b, addr_dst, rs1, rs2,
      output instr_ready, addr_rs1, addr_rs2, addr_rd, we, data_in, result, done
   );

   modport master (
      output instr_valid, op, addr_a, addr_b, addr_dst, rs1, rs2,
      input  instr_ready, addr_rs1, addr_rs2, addr_rd, we, data_in, result, done
   );
endinterface

// File: rtl/module_unidad_ejecucion.sv
// rtl/module_unidad_ejecucion.sv - single-issue execution stage: read operands, ALU or shift-add multiply, write back
module module_unidad_ejecucion #(
   parameter int N = 32,
   parameter int W = 8
) (
   input logic clk,
   input logic rst,
   module_unidad_ejecucion_if.slave bus
);
   localparam int AW  = $clog2(N);
   localparam int SHW = $clog2(W);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_EXEC, S_MUL, S_WB} state_t;

   state_t        state;
   logic [2:0]    op_q;
   logic [AW-1:0] dst_q;
   logic [W-1:0]  opa, opb, acc;
   logic [SHW-1:0] cnt;
   logic          ready_q, we_q, done_q;
   logic [W-1:0]  result_q, data_q;
   logic [AW-1:0] addr_rs1_q, addr_rs2_q, addr_rd_q;
   logic [W-1:0]  alu_res, acc_next;

   always_comb begin
      alu_res = '0;
      case (op_q)
         3'b000:  alu_res = opa + opb;
         3'b001:  alu_res = opa - opb;
         3'b010:  alu_res = opa & opb;
         3'b011:  alu_res = opa | opb;
         3'b100:  alu_res = opa ^ opb;
         3'b101:  alu_res = opa << opb[SHW-1:0];
         3'b110:  alu_res = opa >> opb[SHW-1:0];
         default: alu_res = '0;
      endcase
   end

   // One multiplier bit per cycle; the counter doubles as the partial-product shift.
   always_comb begin
      acc_next = acc;
      if (opb[cnt])
         acc_next = acc + (opa << cnt);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         op_q       <= '0;
         dst_q      <= '0;
         opa        <= '0;
         opb        <= '0;
         acc        <= '0;
         cnt        <= '0;
         ready_q    <= 1'b1;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         data_q     <= '0;
         addr_rs1_q <= '0;
         addr_rs2_q <= '0;
         addr_rd_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.instr_valid && ready_q) begin
                  op_q       <= bus.op;
                  dst_q      <= bus.addr_dst;
                  addr_rs1_q <= bus.addr_a;
                  addr_rs2_q <= bus.addr_b;
                  ready_q    <= 1'b0;
                  state      <= S_READ;
               end
            end
            S_READ: begin
               opa   <= bus.rs1;
               opb   <= bus.rs2;
               acc   <= '0;
               cnt   <= '0;
               state <= (op_q == 3'b111) ? S_MUL : S_EXEC;
            end
            S_EXEC: begin
               data_q    <= alu_res;
               result_q  <= alu_res;
               addr_rd_q <= dst_q;
               we_q      <= 1'b1;
               done_q    <= 1'b1;
               state     <= S_WB;
            end
            S_MUL: begin
               acc <= acc_next;
               cnt <= cnt + 1'b1;
               if (cnt == SHW'(W-1)) begin
                  data_q    <= acc_next;
                  result_q  <= acc_next;
                  addr_rd_q <= dst_q;
                  we_q      <= 1'b1;
                  done_q    <= 1'b1;
                  state     <= S_WB;
               end
            end
            S_WB: begin
               we_q    <= 1'b0;
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.instr_ready = ready_q;
   assign bus.addr_rs1    = addr_rs1_q;
   assign bus.addr_rs2    = addr_rs2_q;
   assign bus.addr_rd     = addr_rd_q;
   assign bus.we          = we_q;
   assign bus.done        = done_q;
   assign bus.data_in     = data_q;
   assign bus.result      = result_q;
endmodule

// File: tb/tb_module_unidad_ejecucion.sv
// tb/tb_module_unidad_ejecucion.sv - directed and random checks of the execution stage against a register-file model
module tb_module_unidad_ejecucion;
   localparam int N = 32;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;

   module_unidad_ejecucion_if #(.N(N), .W(W)) bus ();
   module_unidad_ejecucion #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Attached register bank: register 0 reads as zero and ignores writes.
   logic [W-1:0] bank [N];
   logic         pre_we = 1'b0;
   logic [4:0]   pre_addr = '0;
   logic [W-1:0] pre_data = '0;
   logic [W-1:0] ref_rf [N];

   always @(posedge clk) begin
      if (pre_we)
         bank[pre_addr] <= pre_data;
      else if (bus.we && bus.addr_rd != 5'd0)
         bank[bus.addr_rd] <= bus.data_in;
   end
   assign bus.rs1 = bank[bus.addr_rs1];
   assign bus.rs2 = bank[bus.addr_rs2];

   function automatic logic [W-1:0] model(input int op, input int a, input int b);
      int r;
      case (op)
         0: r = a + b;
         1: r = a - b + 256;
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = a * (2 ** (b % 8));
         6: r = a / (2 ** (b % 8));
         default: r = a * b;
      endcase
      return W'(r % 256);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic poke(input int addr, input int val);
      pre_we   = 1'b1;
      pre_addr = 5'(addr);
      pre_data = W'(val);
      ref_rf[addr] = (addr == 0) ? '0 : W'(val);
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Called at a falling edge with the block idle; returns at the falling edge of the cycle after WB.
   task automatic run(input int op, input int a, input int b, input int dst, input bit keep);
      logic [W-1:0] exp;
      int cyc, lat, lat_exp;
      exp = model(op, int'(ref_rf[a]), int'(ref_rf[b]));
      lat_exp = (op == 7) ? W + 2 : 3;
      bus.op = 3'(op);
      bus.addr_a = 5'(a);
      bus.addr_b = 5'(b);
      bus.addr_dst = 5'(dst);
      bus.instr_valid = 1'b1;
      cyc = 0;
      while (!bus.instr_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("accept_wait", cyc, 0);
      @(posedge clk);
      @(negedge clk);
      lat = 1;
      chk("busy_ready", bus.instr_ready, 0);
      if (!keep) bus.instr_valid = 1'b0;
      while (!bus.we && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", lat, lat_exp);
      chk("data_in", bus.data_in, exp);
      chk("done", bus.done, 1);
      chk("addr_rd", bus.addr_rd, dst);
      if (dst != 0) ref_rf[dst] = exp;
      @(negedge clk);
      bus.instr_valid = 1'b0;
      chk("we_low", bus.we, 0);
      chk("done_low", bus.done, 0);
      chk("result", bus.result, exp);
      chk("bank", bank[dst], ref_rf[dst]);
      chk("ready_back", bus.instr_ready, 1);
   endtask

   initial begin
      int wes;
      bus.instr_valid = 1'b0;
      bus.op = '0;
      bus.addr_a = '0;
      bus.addr_b = '0;
      bus.addr_dst = '0;
      for (int i = 0; i < N; i++) poke(i, 0);

      chk("rst_we", bus.we, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_result", bus.result, 0);
      chk("rst_data_in", bus.data_in, 0);
      chk("rst_addr_rd", bus.addr_rd, 0);
      chk("rst_addr_rs1", bus.addr_rs1, 0);
      chk("rst_ready", bus.instr_ready, 1);
      rst = 1'b1;
      @(negedge clk);

      poke(1, 200); poke(2, 100);
      run(0, 1, 2, 3, 0);

      poke(1, 5); poke(2, 9);
      run(1, 1, 2, 4, 0);
      run(5, 1, 2, 5, 0);

      poke(1, 13); poke(2, 11);
      run(7, 1, 2, 6, 0);
      poke(1, 20); poke(2, 15);
      run(7, 1, 2, 6, 0);

      run(0, 1, 2, 3, 0);
      run(4, 3, 1, 7, 0);

      run(0, 1, 2, 0, 1);
      chk("r0_zero", bank[0], 0);

      // Abort a multiply four cycles after accept.
      bus.op = 3'b111;
      bus.addr_a = 5'd1;
      bus.addr_b = 5'd2;
      bus.addr_dst = 5'd9;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_we", bus.we, 0);
      chk("abort_result", bus.result, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_ready", bus.instr_ready, 1);
      wes = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.we) wes++;
      end
      chk("abort_no_wb", wes, 0);
      chk("abort_bank", bank[9], ref_rf[9]);

      for (int i = 1; i < 8; i++) poke(i, int'($urandom_range(0, 255)));
      for (int k = 0; k < 24; k++) begin
         run(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
